seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a loaded word out LSB-first on w, optionally looping,
// and predicts the paired run-length detector output on z_exp one cycle behind the stream.
module seq_pattern_gen #(
   parameter int MAX_LEN = 16,
   parameter int RUN_LEN = 4,
   parameter int LEN_W   = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [MAX_LEN-1:0] load_data,
   input  logic [LEN_W-1:0]   load_len,
   input  logic               load_repeat,
   input  logic               stop,
   output logic               w,
   output logic               w_valid,
   output logic               busy,
   output logic               z_exp,
   output logic               done
);

   localparam int RUN_W = $clog2(RUN_LEN + 1);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(RUN_LEN);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t             state_q;
   logic [MAX_LEN-1:0] sh_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt_q;
   logic               rep_q;
   logic               stop_q;
   logic               w_q;
   logic               wv_q;
   logic               busy_q;
   logic               rdy_q;
   logic               done_q;
   logic               z_q;
   logic               prev_q;
   logic [RUN_W-1:0]   run_q;

   logic [LEN_W-1:0]   len_d;
   logic [RUN_W-1:0]   run_d;
   logic               stop_d;
   logic               last_bit;

   always_comb begin
      len_d    = (load_len > MAX_LEN_L) ? MAX_LEN_L : load_len;
      stop_d   = stop_q | stop;
      last_bit = (cnt_q + LEN_W'(1)) == len_q;
      // Run length of the stream including the bit currently on w
      run_d    = '0;
      if (wv_q) begin
         if (run_q != '0 && w_q == prev_q) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
         end else begin
            run_d = RUN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         rep_q   <= 1'b0;
         stop_q  <= 1'b0;
         w_q     <= 1'b0;
         wv_q    <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b1;
         done_q  <= 1'b0;
         z_q     <= 1'b0;
         prev_q  <= 1'b0;
         run_q   <= '0;
      end else begin
         run_q  <= run_d;
         prev_q <= w_q;
         z_q    <= (run_d == RUN_MAX);
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               wv_q   <= 1'b0;
               if (load_valid && rdy_q) begin
                  if (len_d == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                     sh_q    <= load_data >> 1;
                     pat_q   <= load_data;
                     len_q   <= len_d;
                     rep_q   <= load_repeat;
                     cnt_q   <= '0;
                     stop_q  <= 1'b0;
                     w_q     <= load_data[0];
                     wv_q    <= 1'b1;
                     busy_q  <= 1'b1;
                     rdy_q   <= 1'b0;
                  end
               end
            end
            S_SHIFT: begin
               if (!last_bit) begin
                  w_q    <= sh_q[0];
                  sh_q   <= sh_q >> 1;
                  cnt_q  <= cnt_q + LEN_W'(1);
                  stop_q <= stop_d;
               end else if (rep_q && !stop_d) begin
                  w_q    <= pat_q[0];
                  sh_q   <= pat_q >> 1;
                  cnt_q  <= '0;
                  stop_q <= 1'b0;
               end else begin
                  state_q <= S_IDLE;
                  stop_q  <= 1'b0;
                  wv_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign load_ready = rdy_q;
   assign w          = w_q;
   assign w_valid    = wv_q;
   assign busy       = busy_q;
   assign z_exp      = z_q;
   assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed scenarios then random traffic, checked each cycle
// against a queue-based model of the stream and a history-window model of the detector.
module tb_seq_pattern_gen;

   localparam int MAX = 16;
   localparam int RUN = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [4:0]  load_len;
   logic        load_repeat;
   logic        stop;
   logic        w, w_valid, busy, z_exp, done;

   int tests = 0;
   int fails = 0;

   seq_pattern_gen #(.MAX_LEN(MAX), .RUN_LEN(RUN), .LEN_W(5)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat), .stop(stop),
      .w(w), .w_valid(w_valid), .busy(busy), .z_exp(z_exp), .done(done)
   );

   always #5 clk = ~clk;

   // Model state: expected outputs of the current cycle plus pending bits
   logic m_w = 0, m_wv = 0, m_busy = 0, m_rdy = 1, m_done = 0, m_z = 0;
   bit   pend[$];
   bit   pat[$];
   bit   hv[$];
   bit   hw[$];
   bit   m_rep = 0, m_stopped = 0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic predict();
      bit cur_v, cur_w, nz;
      int L;
      cur_v = m_wv;
      cur_w = m_w;
      hv.push_back(cur_v);
      hw.push_back(cur_w);
      if (hv.size() > RUN) begin
         void'(hv.pop_front());
         void'(hw.pop_front());
      end
      // Detector fires after RUN valid, identical bits in a row
      nz = (hv.size() == RUN);
      for (int i = 0; i < hv.size(); i++)
         if (!hv[i] || hw[i] != hw[0]) nz = 0;
      if (reset) begin
         m_w = 0; m_wv = 0; m_busy = 0; m_rdy = 1; m_done = 0; m_z = 0;
         pend.delete(); hv.delete(); hw.delete();
      end else begin
         m_z = nz;
         if (!cur_v) begin
            m_done = 0;
            if (load_valid) begin
               L = (int'(load_len) > MAX) ? MAX : int'(load_len);
               if (L == 0) begin
                  m_done = 1;
               end else begin
                  pat.delete();
                  for (int i = 0; i < L; i++) pat.push_back(load_data[i]);
                  pend = pat;
                  m_rep = load_repeat;
                  m_stopped = 0;
                  m_w = pend.pop_front();
                  m_wv = 1; m_busy = 1; m_rdy = 0;
               end
            end
         end else begin
            m_stopped = m_stopped | stop;
            if (pend.size() == 0 && m_rep && !m_stopped) pend = pat;
            if (pend.size() > 0) begin
               m_w = pend.pop_front();
            end else begin
               m_wv = 0; m_busy = 0; m_rdy = 1; m_done = 1;
            end
         end
      end
   endtask

   task automatic cyc(input logic rst, input logic lv, input logic [15:0] d,
                      input logic [4:0] len, input logic rep, input logic stp);
      reset = rst; load_valid = lv; load_data = d; load_len = len;
      load_repeat = rep; stop = stp;
      predict();
      @(posedge clk);
      #1;
      chk("w",          w,          m_w);
      chk("w_valid",    w_valid,    m_wv);
      chk("busy",       busy,       m_busy);
      chk("load_ready", load_ready, m_rdy);
      chk("done",       done,       m_done);
      chk("z_exp",      z_exp,      m_z);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 5'd0, 0, 0);
   endtask

   int done_cnt;

   initial begin
      // Reset values
      cyc(1, 0, 16'h0, 5'd0, 0, 0);
      cyc(1, 1, 16'hFFFF, 5'd8, 0, 0);
      idle(2);

      // Single pass, run of four ones then four zeros
      cyc(0, 1, 16'h000F, 5'd8, 0, 0);
      idle(10);

      // Repeating 1010 with stop in the second pass; count done pulses
      cyc(0, 1, 16'h0005, 5'd4, 1, 0);
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 16'h0, 5'd0, 0, 0);
         if (done) done_cnt++;
      end
      cyc(0, 0, 16'h0, 5'd0, 0, 1);
      if (done) done_cnt++;
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 16'h0, 5'd0, 0, 0);
         if (done) done_cnt++;
      end
      tests++;
      assert (done_cnt == 1) else begin
         fails++;
         $error("FAIL repeat_done_count observed=%0d expected=1", done_cnt);
      end

      // Zero-length load
      cyc(0, 1, 16'h0000, 5'd0, 0, 0);
      idle(3);

      // Over-long length clamps to 16
      cyc(0, 1, 16'hFFFF, 5'd31, 0, 0);
      idle(19);

      // Reset mid-pattern, then immediate reload
      cyc(0, 1, 16'h00A7, 5'd8, 0, 0);
      idle(2);
      cyc(1, 0, 16'h0, 5'd0, 0, 0);
      cyc(0, 1, 16'h0033, 5'd6, 0, 0);
      idle(8);

      // load_valid held through SHIFT; second pattern taken in the done cycle
      cyc(0, 1, 16'h00C3, 5'd8, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 16'h001E, 5'd5, 0, 0);
      idle(8);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 3) == 0),
             16'($urandom),
             5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      end
      idle(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
